// File: rtl/divider_unit.sv
`default_nettype none
// ============================================================================
// Module      : divider_unit
// Description : Iterative restoring divider for the RV32M DIV/DIVU/REM/REMU
//               instructions. One quotient bit per clock in CALC state,
//               sign fix-up and special-case substitution on the final edge.
//               Optional macro DIVIDER_FAST_SPECIAL_EN: divide-by-zero and
//               signed overflow bypass CALC and finish one cycle after accept.
// Revision    : 1.0 - initial release
// ============================================================================
module divider_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic [6:0]       funct7,
  input  logic             funct7_valid,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] bus_rs1,
  input  logic [WIDTH-1:0] bus_rs2,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] div_output
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] c_COUNT_INIT = CW'(WIDTH - 1);
  localparam logic [14:0]   c_DIV_DECODE = 15'b1_0000001_0110011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_rem;       // partial remainder magnitude
  logic [WIDTH-1:0] r_quo;       // dividend bits shifting out, quotient bits in
  logic [WIDTH-1:0] r_divisor;   // divisor magnitude
  logic             r_is_rem;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_div_zero;
  logic [WIDTH-1:0] r_div_output;

  logic             w_accept;
  logic             w_load;
  logic             w_finish;
  logic             w_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_qbit;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;
  logic [WIDTH-1:0] w_q_final;
  logic [WIDTH-1:0] w_r_final;

  // Instruction decode and operand magnitude preparation
  assign w_accept = start && (r_state == S_IDLE) &&
                    ({funct7_valid, funct7, opcode} == c_DIV_DECODE) && funct3[2];
  assign w_signed = ~funct3[0];
  assign w_a_neg  = w_signed & bus_rs1[WIDTH-1];
  assign w_b_neg  = w_signed & bus_rs2[WIDTH-1];
  assign w_a_mag  = w_a_neg ? (~bus_rs1 + 1'b1) : bus_rs1;
  assign w_b_mag  = w_b_neg ? (~bus_rs2 + 1'b1) : bus_rs2;

`ifdef DIVIDER_FAST_SPECIAL_EN
  logic             w_special;
  logic             w_fast;
  logic [WIDTH-1:0] w_fast_result;
  // Divide-by-zero or most-negative / -1: result known without iterating
  assign w_special = (bus_rs2 == '0) ||
                     (w_signed && (bus_rs1 == {1'b1, {(WIDTH-1){1'b0}}}) && (&bus_rs2));
  assign w_fast_result = (bus_rs2 == '0) ? (funct3[1] ? bus_rs1 : '1)
                                         : (funct3[1] ? '0 : bus_rs1);
`endif

  // One restoring shift-subtract step
  assign w_shift    = {r_rem, r_quo[WIDTH-1]};
  assign w_trial    = w_shift - {1'b0, r_divisor};
  assign w_qbit     = ~w_trial[WIDTH];
  assign w_rem_next = w_qbit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quo_next = {r_quo[WIDTH-2:0], w_qbit};

  // Sign fix-up; a zero divisor forces an all-ones quotient, while the
  // remainder path naturally reproduces the dividend in that case
  assign w_q_final = r_div_zero ? '1 : (r_neg_q ? (~w_quo_next + 1'b1) : w_quo_next);
  assign w_r_final = r_neg_r ? (~w_rem_next + 1'b1) : w_rem_next;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state and control decode
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_finish     = 1'b0;
`ifdef DIVIDER_FAST_SPECIAL_EN
    w_fast       = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
`ifdef DIVIDER_FAST_SPECIAL_EN
          if (w_special) begin
            w_state_next = S_DONE;
            w_fast       = 1'b1;
          end else begin
            w_state_next = S_CALC;
            w_load       = 1'b1;
          end
`else
          w_state_next = S_CALC;
          w_load       = 1'b1;
`endif
        end
      end
      S_CALC: begin
        if (r_count == '0) begin
          w_state_next = S_DONE;
          w_finish     = 1'b1;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Operand latch and iteration datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count    <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_divisor  <= '0;
      r_is_rem   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div_zero <= 1'b0;
    end else if (w_load) begin
      r_count    <= c_COUNT_INIT;
      r_rem      <= '0;
      r_quo      <= w_a_mag;
      r_divisor  <= w_b_mag;
      r_is_rem   <= funct3[1];
      r_neg_q    <= w_a_neg ^ w_b_neg;
      r_neg_r    <= w_a_neg;
      r_div_zero <= (bus_rs2 == '0);
    end else if (r_state == S_CALC) begin
      r_count    <= r_count - 1'b1;
      r_rem      <= w_rem_next;
      r_quo      <= w_quo_next;
    end
  end

  // Result register, written only on the edge that enters DONE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div_output <= '0;
    end else if (w_finish) begin
      r_div_output <= r_is_rem ? w_r_final : w_q_final;
`ifdef DIVIDER_FAST_SPECIAL_EN
    end else if (w_fast) begin
      r_div_output <= w_fast_result;
`endif
    end
  end

  assign busy       = (r_state == S_CALC);
  assign done       = (r_state == S_DONE);
  assign div_output = r_div_output;

endmodule
`default_nettype wire

// File: tb/tb_divider_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_divider_unit
// Description : Self-checking bench for divider_unit (WIDTH=32): directed
//               corner cases, randomized operations against an arithmetic
//               reference model, decode filtering and mid-operation reset.
//               Follows DIVIDER_FAST_SPECIAL_EN for expected special latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_divider_unit;

  localparam int WIDTH = 32;

  logic             clk;
  logic             reset;
  logic [6:0]       opcode;
  logic [6:0]       funct7;
  logic             funct7_valid;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] bus_rs1;
  logic [WIDTH-1:0] bus_rs2;
  logic             start;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] div_output;

  int n_cmp = 0;
  int n_err = 0;

  divider_unit #(.WIDTH(WIDTH)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .funct7       (funct7),
    .funct7_valid (funct7_valid),
    .funct3       (funct3),
    .bus_rs1      (bus_rs1),
    .bus_rs2      (bus_rs2),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .div_output   (div_output)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return (b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Reference: RISC-V M-extension division semantics in plain arithmetic
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    bit ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'b100:  return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
      3'b101:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110:  return (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic drive_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    opcode       = 7'b0110011;
    funct7       = 7'b0000001;
    funct7_valid = 1'b1;
    funct3       = f3;
    bus_rs1      = a;
    bus_rs2      = b;
    start        = 1'b1;
  endtask

  // Issue one operation and watch 40 cycles: latency, busy length, result,
  // single done pulse and result hold. Operands are scrambled after accept;
  // with disturb set, further decoded starts arrive while the unit iterates.
  task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input bit disturb, input bit rel);
    int done_cyc, busy_cnt, done_cnt, exp_lat, exp_busy;
    logic [31:0] res, exp;
    bit fast;
    exp = model(f3, a, b);
`ifdef DIVIDER_FAST_SPECIAL_EN
    fast = is_special(f3, a, b);
`else
    fast = 1'b0;
`endif
    exp_lat  = fast ? 1 : 33;
    exp_busy = fast ? 0 : 32;
    done_cyc = -1;
    busy_cnt = 0;
    done_cnt = 0;
    res      = 32'h0;
    @(negedge clk);
    drive_req(f3, a, b);
    if (rel) reset = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk);
      #1;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          res      = div_output;
        end
      end
      @(negedge clk);
      bus_rs1 = $urandom;
      bus_rs2 = $urandom;
      start   = (disturb && !fast && cyc < 30) ? ($urandom_range(0, 2) == 0) : 1'b0;
      funct3  = {1'b1, 2'($urandom)};
    end
    start = 1'b0;
    check({tag, ".lat"},    32'(done_cyc), 32'(exp_lat));
    check({tag, ".busy"},   32'(busy_cnt), 32'(exp_busy));
    check({tag, ".ndone"},  32'(done_cnt), 32'd1);
    check({tag, ".result"}, res, exp);
    check({tag, ".hold"},   div_output, exp);
  endtask

  initial begin
    logic [31:0] prev;
    int          dn;
    reset = 1'b0;
    opcode = '0; funct7 = '0; funct7_valid = 1'b0; funct3 = '0;
    bus_rs1 = '0; bus_rs2 = '0; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.out",  div_output, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Directed corner cases
    do_op("div_100_m7",   3'b100, 32'd100,         32'hFFFF_FFF9, 1'b0, 1'b0);
    check("div_100_m7.val", div_output, 32'hFFFF_FFF2);
    do_op("rem_m100_7",   3'b110, 32'hFFFF_FF9C,   32'd7,         1'b0, 1'b0);
    check("rem_m100_7.val", div_output, 32'hFFFF_FFFE);
    do_op("remu_ff_16",   3'b111, 32'hFFFF_FFFF,   32'd16,        1'b0, 1'b0);
    check("remu_ff_16.val", div_output, 32'h0000_000F);
    do_op("divu_5_0",     3'b101, 32'd5,           32'd0,         1'b0, 1'b0);
    do_op("rem_5_0",      3'b110, 32'd5,           32'd0,         1'b0, 1'b0);
    do_op("div_m5_0",     3'b100, 32'hFFFF_FFFB,   32'd0,         1'b0, 1'b0);
    do_op("rem_m5_0",     3'b110, 32'hFFFF_FFFB,   32'd0,         1'b0, 1'b0);
    do_op("div_ovf",      3'b100, 32'h8000_0000,   32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op("rem_ovf",      3'b110, 32'h8000_0000,   32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op("divu_big",     3'b101, 32'h8000_0000,   32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op("div_dist",     3'b100, 32'd12345,       32'hFFFF_FFF0, 1'b1, 1'b0);

    // Starts that do not decode as divide must be ignored
    prev = div_output;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive_req(3'b100, 32'd77, 32'd3);
      case (k)
        0: funct7       = 7'b0000000;
        1: funct3       = 3'b000;
        2: funct7_valid = 1'b0;
        default: opcode = 7'b0010011;
      endcase
      dn = 0;
      for (int c = 0; c < 3; c++) begin
        @(posedge clk);
        #1;
        if (busy || done) dn++;
      end
      check($sformatf("nodec%0d.act", k), 32'(dn), 32'd0);
      check($sformatf("nodec%0d.out", k), div_output, prev);
    end
    @(negedge clk);
    start = 1'b0;

    // Randomized operations
    for (int n = 0; n < 40; n++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      f3 = {1'b1, 2'($urandom)};
      a  = $urandom;
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2:       b = 32'($urandom_range(1, 15));
        3:       b = -32'($urandom_range(1, 15));
        4:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      do_op($sformatf("rnd%0d", n), f3, a, b, 1'($urandom), 1'b0);
    end

    // Reset in the middle of CALC abandons the operation
    @(negedge clk);
    drive_req(3'b100, 32'h7FFF_0000, 32'd3);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("rstmid.busy", 32'(busy), 32'd0);
    check("rstmid.done", 32'(done), 32'd0);
    check("rstmid.out",  div_output, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    dn = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (done || busy) dn++;
    end
    check("rstmid.noact", 32'(dn), 32'd0);

    // Request presented on the very first edge after reset release
    @(negedge clk);
    reset = 1'b0;
    do_op("divu_42_5", 3'b101, 32'd42, 32'd5, 1'b0, 1'b1);
    check("divu_42_5.val", div_output, 32'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/divider_unit.md
DIVIDER_UNIT -- requirements
Module: divider_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width and iteration count.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port opcode  input  7  instruction opcode.
REQ-005 SHALL have port funct7  input  7  instruction funct7.
REQ-006 SHALL have port funct7_valid  input  1  funct7 field meaningful (R-type).
REQ-007 SHALL have port funct3  input  3  selects DIV=100, DIVU=101, REM=110, REMU=111.
REQ-008 SHALL have port bus_rs1  input  WIDTH  dividend.
REQ-009 SHALL have port bus_rs2  input  WIDTH  divisor.
REQ-010 SHALL have port start  input  1  request to begin an operation.
REQ-011 SHALL have port busy  output  1  high while iterating.
REQ-012 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-013 SHALL have port div_output  output  WIDTH  registered result.

Function
REQ-014 SHALL accept a request only on an edge where start=1, state=IDLE, {funct7_valid,funct7,opcode}=1_0000001_0110011 and funct3[2]=1.
REQ-015 SHALL ignore start when not decoded as a divide op (stay IDLE, no done) or when state is not IDLE.
REQ-016 SHALL latch operands and funct3 at the accept edge; later input changes do not affect the operation.
REQ-017 SHALL implement states IDLE, CALC, DONE: IDLE->CALC on accept; CALC->DONE after exactly WIDTH CALC edges; DONE->IDLE unconditionally next edge.
REQ-018 SHALL compute one quotient bit per CALC edge (restoring or non-restoring shift-subtract on magnitudes), using a counter that counts WIDTH-1 down to 0.
REQ-019 SHALL drive busy=1 exactly in CALC, done=1 exactly in DONE.
REQ-020 SHALL, normal path, assert done WIDTH+1 cycles after the accept edge (33 for WIDTH=32).
REQ-021 SHALL for DIV/REM use magnitudes, negate quotient when operand signs differ, give remainder the sign of the dividend.
REQ-022 SHALL for DIVU/REMU treat operands unsigned.
REQ-023 SHALL on divisor=0 return all ones for DIV/DIVU and the dividend for REM/REMU.
REQ-024 SHALL on signed overflow (DIV/REM, dividend=-2^(WIDTH-1), divisor=-1) return quotient -2^(WIDTH-1), remainder 0.
REQ-025 SHALL update div_output at the edge entering DONE and hold it until the next such edge or reset.
REQ-026 SHALL select quotient for DIV/DIVU, remainder for REM/REMU.

Reset
REQ-027 SHALL on reset=0, asynchronously and regardless of state, force state=IDLE, busy=0, done=0, div_output=0, counter and datapath registers 0.
REQ-028 SHALL abandon an in-flight operation on reset and produce no done for it after release.
REQ-029 SHALL accept a new request on the first rising edge with reset=1.

Configuration
REQ-030 SHALL honour macro DIVIDER_FAST_SPECIAL_EN: when defined, divisor=0 and signed-overflow cases go IDLE->DONE directly, done 1 cycle after accept, busy never high.
REQ-031 SHALL, without DIVIDER_FAST_SPECIAL_EN, run special cases through full WIDTH CALC cycles with results still per REQ-023/REQ-024.
REQ-032 SHALL keep normal-case latency and results identical with or without the macro.

Verification
REQ-033 DIV 100 / -7 -> div_output 0xFFFFFFF2 (-14), done 33 cycles after accept, busy high 32 cycles.
REQ-034 REM -100 / 7 -> 0xFFFFFFFE (-2); REMU 0xFFFFFFFF / 16 -> 0x0000000F.
REQ-035 DIVU 5 / 0 -> 0xFFFFFFFF; REM 5 / 0 -> 5; DIV 0x80000000 / -1 -> 0x80000000, REM same operands -> 0; done at cycle 1 with macro, cycle 33 without.
REQ-036 start with funct7=0000000 or funct3=000, and start pulsed during CALC -> no state change, no extra done, result of running op unaffected.
REQ-037 reset asserted at CALC cycle 10 -> busy/done/div_output 0 immediately; no done after release; next DIVU 42 / 5 -> 8 at cycle 33.
